// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, mcycle/minstret counters, a combinational
// read port for execute, and the pending-interrupt request for commit.
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] HART_ID   = 32'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb2csrfile_wr_reg,
    input  logic [11:0] wb2csrfile_wr_regindex,
    input  logic [31:0] wb2csrfile_wr_wdata,
    input  logic [11:0] csr_rd_index,
    output logic [31:0] csr_rd_data,
    output logic        csr_rd_illegal,
    input  logic        trap_take,
    input  logic        trap_is_int,
    input  logic [3:0]  trap_code,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        instret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic        irq_pending,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;
    logic [31:0] mtvec_base;

    logic        wr_mstatus;
    logic        wr_mie;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mtval;
    logic        wr_mcycle;
    logic        wr_mcycleh;
    logic        wr_minstret;
    logic        wr_minstreth;

    logic        mret_eff;
    logic        instret_eff;
    logic [63:0] mcycle_inc;
    logic [63:0] minstret_inc;
    logic [63:0] mcycle_nxt;
    logic [63:0] minstret_nxt;
    logic [31:0] mtvec_wval;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mip_val     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
    assign mtvec_base  = {mtvec_q[31:2], 2'b00};

    // Trap beats mret beats the writeback port; only overlapping fields lose.
    always_comb begin
        mret_eff     = mret && !trap_take;
        instret_eff  = instret && !trap_take;
        wr_mstatus   = 1'b0;
        wr_mie       = 1'b0;
        wr_mtvec     = 1'b0;
        wr_mscratch  = 1'b0;
        wr_mepc      = 1'b0;
        wr_mcause    = 1'b0;
        wr_mtval     = 1'b0;
        wr_mcycle    = 1'b0;
        wr_mcycleh   = 1'b0;
        wr_minstret  = 1'b0;
        wr_minstreth = 1'b0;
        if (wb2csrfile_wr_reg) begin
            case (wb2csrfile_wr_regindex)
                ADDR_MSTATUS:   wr_mstatus   = !trap_take && !mret;
                ADDR_MIE:       wr_mie       = 1'b1;
                ADDR_MTVEC:     wr_mtvec     = 1'b1;
                ADDR_MSCRATCH:  wr_mscratch  = 1'b1;
                ADDR_MEPC:      wr_mepc      = !trap_take;
                ADDR_MCAUSE:    wr_mcause    = !trap_take;
                ADDR_MTVAL:     wr_mtval     = !trap_take;
                ADDR_MCYCLE:    wr_mcycle    = 1'b1;
                ADDR_MCYCLEH:   wr_mcycleh   = 1'b1;
                ADDR_MINSTRET:  wr_minstret  = 1'b1;
                ADDR_MINSTRETH: wr_minstreth = 1'b1;
                default: ;
            endcase
        end
    end

    // Mode values 2 and 3 collapse to direct.
    assign mtvec_wval = {wb2csrfile_wr_wdata[31:2], 1'b0,
                         (wb2csrfile_wr_wdata[1:0] == 2'b01)};

    // A half-word write replaces only that half; the other half keeps the carry.
    always_comb begin
        mcycle_inc   = mcycle_q + 64'd1;
        minstret_inc = minstret_q + {63'b0, instret_eff};
        mcycle_nxt   = mcycle_inc;
        minstret_nxt = minstret_inc;
        if (wr_mcycle)    mcycle_nxt[31:0]    = wb2csrfile_wr_wdata;
        if (wr_mcycleh)   mcycle_nxt[63:32]   = wb2csrfile_wr_wdata;
        if (wr_minstret)  minstret_nxt[31:0]  = wb2csrfile_wr_wdata;
        if (wr_minstreth) minstret_nxt[63:32] = wb2csrfile_wr_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= 32'b0;
            mtvec_q      <= MTVEC_RST;
            mscratch_q   <= 32'b0;
            mepc_q       <= 32'b0;
            mcause_q     <= 32'b0;
            mtval_q      <= 32'b0;
            mcycle_q     <= 64'b0;
            minstret_q   <= 64'b0;
        end else begin
            mcycle_q   <= mcycle_nxt;
            minstret_q <= minstret_nxt;

            if (trap_take) begin
                mepc_q       <= {trap_pc[31:2], 2'b00};
                mcause_q     <= {trap_is_int, 27'b0, trap_code};
                mtval_q      <= trap_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_eff) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end

            if (wr_mstatus) begin
                mstatus_mie  <= wb2csrfile_wr_wdata[3];
                mstatus_mpie <= wb2csrfile_wr_wdata[7];
            end
            if (wr_mie)      mie_q      <= wb2csrfile_wr_wdata & MIE_WMASK;
            if (wr_mtvec)    mtvec_q    <= mtvec_wval;
            if (wr_mscratch) mscratch_q <= wb2csrfile_wr_wdata;
            if (wr_mepc)     mepc_q     <= {wb2csrfile_wr_wdata[31:2], 2'b00};
            if (wr_mcause)   mcause_q   <= wb2csrfile_wr_wdata;
            if (wr_mtval)    mtval_q    <= wb2csrfile_wr_wdata;
        end
    end

    always_comb begin
        csr_rd_data    = 32'b0;
        csr_rd_illegal = 1'b0;
        case (csr_rd_index)
            ADDR_MSTATUS:   csr_rd_data = mstatus_val;
            ADDR_MIE:       csr_rd_data = mie_q;
            ADDR_MTVEC:     csr_rd_data = mtvec_q;
            ADDR_MSCRATCH:  csr_rd_data = mscratch_q;
            ADDR_MEPC:      csr_rd_data = mepc_q;
            ADDR_MCAUSE:    csr_rd_data = mcause_q;
            ADDR_MTVAL:     csr_rd_data = mtval_q;
            ADDR_MIP:       csr_rd_data = mip_val;
            ADDR_MCYCLE:    csr_rd_data = mcycle_q[31:0];
            ADDR_MCYCLEH:   csr_rd_data = mcycle_q[63:32];
            ADDR_MINSTRET:  csr_rd_data = minstret_q[31:0];
            ADDR_MINSTRETH: csr_rd_data = minstret_q[63:32];
            ADDR_MHARTID:   csr_rd_data = HART_ID;
            default:        csr_rd_illegal = 1'b1;
        endcase
    end

    always_comb begin
        trap_vector = mtvec_base;
        if (trap_is_int && (mtvec_q[1:0] == 2'b01))
            trap_vector = mtvec_base + {26'b0, trap_code, 2'b00};
    end

    assign irq_pending = mstatus_mie && |(mie_q & mip_val);
    assign mepc_out    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a register-level model.
module tb_csr_file;

    localparam logic [31:0] P_MTVEC = 32'h0000_1000;
    localparam logic [31:0] P_HART  = 32'd5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb2csrfile_wr_reg;
    logic [11:0] wb2csrfile_wr_regindex;
    logic [31:0] wb2csrfile_wr_wdata;
    logic [11:0] csr_rd_index;
    logic [31:0] csr_rd_data;
    logic        csr_rd_illegal;
    logic        trap_take;
    logic        trap_is_int;
    logic [3:0]  trap_code;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        instret;
    logic        ext_irq;
    logic        timer_irq;
    logic        irq_pending;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    csr_file #(.MTVEC_RST(P_MTVEC), .HART_ID(P_HART)) dut (
        .clk(clk), .rstn(rstn),
        .wb2csrfile_wr_reg(wb2csrfile_wr_reg),
        .wb2csrfile_wr_regindex(wb2csrfile_wr_regindex),
        .wb2csrfile_wr_wdata(wb2csrfile_wr_wdata),
        .csr_rd_index(csr_rd_index), .csr_rd_data(csr_rd_data),
        .csr_rd_illegal(csr_rd_illegal),
        .trap_take(trap_take), .trap_is_int(trap_is_int), .trap_code(trap_code),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .instret(instret),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .irq_pending(irq_pending),
        .trap_vector(trap_vector), .mepc_out(mepc_out)
    );

    always #10 clk = ~clk;

    // Reference model: architectural register values.
    logic        m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cycle, m_instret;

    always @(posedge clk) begin : model
        logic [63:0] c;
        logic [63:0] n;
        logic [31:0] w;
        logic        wr;
        logic [11:0] a;
        if (!rstn) begin
            m_mie <= 1'b0; m_mpie <= 1'b0; m_ie <= 0; m_tvec <= P_MTVEC;
            m_scratch <= 0; m_epc <= 0; m_cause <= 0; m_tval <= 0;
            m_cycle <= 0; m_instret <= 0;
        end else begin
            wr = wb2csrfile_wr_reg;
            a  = wb2csrfile_wr_regindex;
            w  = wb2csrfile_wr_wdata;
            c = m_cycle + 64'd1;
            n = m_instret + ((instret && !trap_take) ? 64'd1 : 64'd0);
            if (wr && a == 12'hB00) c[31:0]  = w;
            if (wr && a == 12'hB80) c[63:32] = w;
            if (wr && a == 12'hB02) n[31:0]  = w;
            if (wr && a == 12'hB82) n[63:32] = w;
            m_cycle <= c;
            m_instret <= n;
            if (trap_take) begin
                m_epc <= trap_pc & ~32'd3;
                m_cause <= (trap_is_int ? 32'h8000_0000 : 32'd0) | 32'(trap_code);
                m_tval <= trap_tval;
                m_mpie <= m_mie;
                m_mie <= 1'b0;
            end else if (mret) begin
                m_mie <= m_mpie;
                m_mpie <= 1'b1;
            end
            if (wr) begin
                case (a)
                    12'h300: if (!trap_take && !mret) begin m_mie <= w[3]; m_mpie <= w[7]; end
                    12'h304: m_ie <= w & 32'h888;
                    12'h305: m_tvec <= (w & ~32'd3) | ((w[1:0] == 2'd1) ? 32'd1 : 32'd0);
                    12'h340: m_scratch <= w;
                    12'h341: if (!trap_take) m_epc <= w & ~32'd3;
                    12'h342: if (!trap_take) m_cause <= w;
                    12'h343: if (!trap_take) m_tval <= w;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [32:0] model_read(input logic [11:0] idx);
        logic [31:0] mip;
        mip = (ext_irq ? 32'h800 : 32'd0) | (timer_irq ? 32'h80 : 32'd0);
        case (idx)
            12'h300: return {1'b0, 32'h1800 | (m_mie ? 32'h8 : 0) | (m_mpie ? 32'h80 : 0)};
            12'h304: return {1'b0, m_ie};
            12'h305: return {1'b0, m_tvec};
            12'h340: return {1'b0, m_scratch};
            12'h341: return {1'b0, m_epc};
            12'h342: return {1'b0, m_cause};
            12'h343: return {1'b0, m_tval};
            12'h344: return {1'b0, mip};
            12'hB00: return {1'b0, m_cycle[31:0]};
            12'hB80: return {1'b0, m_cycle[63:32]};
            12'hB02: return {1'b0, m_instret[31:0]};
            12'hB82: return {1'b0, m_instret[63:32]};
            12'hF14: return {1'b0, P_HART};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare process: all outputs against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [32:0] r;
            logic [31:0] base;
            logic [31:0] tv;
            logic [31:0] mip;
            r = model_read(csr_rd_index);
            chk("rd_data", csr_rd_data, r[31:0]);
            chk("rd_illegal", {31'b0, csr_rd_illegal}, {31'b0, r[32]});
            base = m_tvec & ~32'd3;
            tv = (trap_is_int && m_tvec[1:0] == 2'd1) ? base + 32'd4 * 32'(trap_code) : base;
            chk("trap_vector", trap_vector, tv);
            mip = (ext_irq ? 32'h800 : 32'd0) | (timer_irq ? 32'h80 : 32'd0);
            chk("irq_pending", {31'b0, irq_pending}, {31'b0, m_mie && ((m_ie & mip) != 0)});
            chk("mepc_out", mepc_out, m_epc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic [11:0] idx, input logic [31:0] exp, input string name);
        csr_rd_index = idx;
        #1;
        chk(name, csr_rd_data, exp);
    endtask

    task automatic csr_write(input logic [11:0] idx, input logic [31:0] w);
        wb2csrfile_wr_reg = 1'b1;
        wb2csrfile_wr_regindex = idx;
        wb2csrfile_wr_wdata = w;
        tick();
        wb2csrfile_wr_reg = 1'b0;
    endtask

    localparam int NADDR = 15;
    logic [11:0] addr_tab [NADDR] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                      12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80,
                                      12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h301};

    initial begin
        rstn = 1'b0; wb2csrfile_wr_reg = 0; wb2csrfile_wr_regindex = 0;
        wb2csrfile_wr_wdata = 0; csr_rd_index = 12'h300; trap_take = 0;
        trap_is_int = 0; trap_code = 0; trap_pc = 0; trap_tval = 0; mret = 0;
        instret = 0; ext_irq = 0; timer_irq = 0;
        tick(); tick();
        chk_en = 1'b1;

        expect_rd(12'h300, 32'h0000_1800, "reset_mstatus");
        expect_rd(12'h305, P_MTVEC, "reset_mtvec");
        expect_rd(12'hB00, 32'd0, "reset_mcycle");
        chk("reset_irq", {31'b0, irq_pending}, 32'd0);

        rstn = 1'b1;
        tick(); tick(); tick();
        expect_rd(12'hB00, 32'd3, "mcycle_since_release");
        expect_rd(12'hF14, P_HART, "mhartid");

        csr_write(12'h305, 32'h8000_0001);
        csr_write(12'h304, 32'h0000_0080);
        csr_write(12'h300, 32'h0000_0008);
        timer_irq = 1'b1;
        #1 chk("irq_pending_set", {31'b0, irq_pending}, 32'd1);
        trap_take = 1; trap_is_int = 1; trap_code = 4'd7; trap_pc = 32'h104; trap_tval = 32'h55;
        #1 chk("trap_vector_vec", trap_vector, 32'h8000_001C);
        tick();
        trap_take = 0;
        expect_rd(12'h342, 32'h8000_0007, "mcause_int");
        expect_rd(12'h300, 32'h0000_1880, "mstatus_after_trap");
        expect_rd(12'h343, 32'h0000_0055, "mtval_trap");
        chk("irq_masked", {31'b0, irq_pending}, 32'd0);
        mret = 1;
        tick();
        mret = 0;
        expect_rd(12'h300, 32'h0000_1888, "mstatus_after_mret");
        timer_irq = 0;

        wb2csrfile_wr_reg = 1; wb2csrfile_wr_regindex = 12'h341; wb2csrfile_wr_wdata = 32'h123;
        trap_take = 1; trap_is_int = 0; trap_code = 4'd2; trap_pc = 32'h400;
        tick();
        wb2csrfile_wr_reg = 0; trap_take = 0;
        expect_rd(12'h341, 32'h0000_0400, "mepc_trap_wins");
        chk("mepc_out_trap", mepc_out, 32'h400);
        csr_write(12'h341, 32'h123);
        expect_rd(12'h341, 32'h0000_0120, "mepc_write_alone");

        csr_write(12'h305, 32'h0000_2003);
        expect_rd(12'h305, 32'h0000_2000, "mtvec_mode3");
        csr_write(12'h304, 32'hFFFF_FFFF);
        expect_rd(12'h304, 32'h0000_0888, "mie_mask");

        csr_write(12'hB00, 32'hFFFF_FFFF);
        expect_rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
        expect_rd(12'hB80, 32'd0, "mcycleh_before");
        tick();
        expect_rd(12'hB00, 32'd0, "mcycle_wrapped");
        expect_rd(12'hB80, 32'd1, "mcycleh_carry");

        csr_write(12'h7C0, 32'hDEAD_BEEF);
        expect_rd(12'h7C0, 32'd0, "unimpl_read");
        chk("unimpl_illegal", {31'b0, csr_rd_illegal}, 32'd1);

        instret = 1;
        tick(); tick(); tick();
        rstn = 0;
        tick();
        expect_rd(12'hB00, 32'd0, "mcycle_reset_mid");
        expect_rd(12'hB02, 32'd0, "minstret_reset_mid");
        rstn = 1; instret = 0;
        tick();

        for (int k = 0; k < 3000; k++) begin
            rstn = ($urandom_range(199) != 0);
            wb2csrfile_wr_reg = ($urandom_range(2) == 0);
            wb2csrfile_wr_regindex = addr_tab[$urandom_range(NADDR - 1)];
            case ($urandom_range(7))
                0: wb2csrfile_wr_wdata = 32'hFFFF_FFFF;
                1: wb2csrfile_wr_wdata = 32'hFFFF_FFFD;
                default: wb2csrfile_wr_wdata = $urandom;
            endcase
            trap_take = ($urandom_range(11) == 0);
            trap_is_int = $urandom_range(1);
            trap_code = 4'($urandom_range(15));
            trap_pc = $urandom;
            trap_tval = $urandom;
            mret = ($urandom_range(9) == 0);
            instret = $urandom_range(1);
            if ($urandom_range(15) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(15) == 0) timer_irq = ~timer_irq;
            csr_rd_index = addr_tab[$urandom_range(NADDR - 1)];
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
